// File: rtl/golden_nonce_collector.sv
// Golden-nonce collector: per-core pending slots, round-robin arbiter and FWFT result FIFO.
// Optional simulation trace of pops and finish-on-done when NONCE_COLLECTOR_TRACE_EN is defined.

module golden_nonce_slot #(
    parameter int NONCE_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               capture,
    input  logic               clear,
    input  logic               grant,
    input  logic               hit,
    input  logic [NONCE_W-1:0] hit_nonce,
    output logic               vld,
    output logic [NONCE_W-1:0] nonce,
    output logic               drop
);
    // A hit on a slot that is granted this cycle refills it instead of dropping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld   <= 1'b0;
            nonce <= '0;
        end else if (clear) begin
            vld <= 1'b0;
        end else if (capture && hit && (!vld || grant)) begin
            vld   <= 1'b1;
            nonce <= hit_nonce;
        end else if (grant) begin
            vld <= 1'b0;
        end
    end

    assign drop = capture && hit && vld && !grant;
endmodule

module golden_nonce_collector #(
    parameter int CHANNELS    = 4,
    parameter int NONCE_W     = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int MAX_RESULTS = 1,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [CHANNELS-1:0]         hit,
    input  logic [CHANNELS*NONCE_W-1:0] hit_nonce,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NONCE_W-1:0]          out_nonce,
    output logic [CH_W-1:0]             out_channel,
    output logic [15:0]                 result_count,
    output logic [15:0]                 drop_count,
    output logic                        done
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef struct packed {
        logic [CH_W-1:0]    ch;
        logic [NONCE_W-1:0] nonce;
    } entry_t;

    state_t state, state_nx;
    logic                               run, leave_run;
    logic [CHANNELS-1:0]                slot_vld, slot_drop, grant;
    logic [CHANNELS-1:0][NONCE_W-1:0]   slot_nonce;
    logic [CH_W-1:0]                    rr_ptr, grant_idx;
    logic                               grant_any;
    entry_t                             mem [FIFO_DEPTH];
    entry_t                             wr_entry, head;
    logic [AW:0]                        wr_ptr, rd_ptr;
    logic                               empty, full, pop, can_accept;
    logic [15:0]                        rc_inc;

    assign run       = (state == RUN);
    assign leave_run = run && (state_nx != RUN);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_slot
        golden_nonce_slot #(.NONCE_W(NONCE_W)) u_slot (
            .clk       (clk),
            .reset     (reset),
            .capture   (run),
            .clear     (leave_run),
            .grant     (grant[g]),
            .hit       (hit[g]),
            .hit_nonce (hit_nonce[g*NONCE_W +: NONCE_W]),
            .vld       (slot_vld[g]),
            .nonce     (slot_nonce[g]),
            .drop      (slot_drop[g])
        );
    end

    // Round-robin search starting at rr_ptr; stalls (no grant) while the FIFO cannot take a word.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        if (run && can_accept) begin
            for (int k = 0; k < CHANNELS; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= CHANNELS) idx = idx - CHANNELS;
                if (!grant_any && slot_vld[idx]) begin
                    grant_any  = 1'b1;
                    grant_idx  = CH_W'(idx);
                    grant[idx] = 1'b1;
                end
            end
        end
    end

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = !empty && out_ready;
    assign can_accept = !full || pop;

    assign wr_entry.ch    = grant_idx;
    assign wr_entry.nonce = slot_nonce[grant_idx];
    assign head           = mem[rd_ptr[AW-1:0]];

    assign out_valid   = !empty;
    assign out_nonce   = empty ? '0 : head.nonce;
    assign out_channel = empty ? '0 : head.ch;
    assign done        = (state == DONE);

    assign rc_inc = (result_count == 16'hFFFF) ? result_count : result_count + 16'd1;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (enable) state_nx = RUN;
            RUN: begin
                if (!enable)
                    state_nx = IDLE;
                else if (pop && MAX_RESULTS != 0 && 32'(rc_inc) == MAX_RESULTS)
                    state_nx = DONE;
            end
            DONE: if (!enable) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            result_count <= '0;
            drop_count   <= '0;
            rr_ptr       <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && enable) begin
                result_count <= '0;
                drop_count   <= '0;
            end else if (run) begin
                if (pop) result_count <= rc_inc;
                if (|slot_drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
            if (grant_any)
                rr_ptr <= (32'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + 1'b1;
            if (grant_any) wr_ptr <= wr_ptr + 1'b1;
            if (pop)       rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (grant_any) mem[wr_ptr[AW-1:0]] <= wr_entry;
    end

`ifdef NONCE_COLLECTOR_TRACE_EN
    logic done_q;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done;
            if (pop) $display("%h %h", out_channel, out_nonce);
            if (done && !done_q) $finish(0);
        end
    end
`else
    // Trace disabled: no system tasks in this build.
`endif
endmodule

// File: tb/tb_golden_nonce_collector.sv
// Bench for golden_nonce_collector: two instances (MAX_RESULTS 0 and 1) on shared stimulus,
// compared each cycle against a behavioural model, plus directed literal checks.

module tb_golden_nonce_collector;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic [3:0]   hit = '0;
    logic [127:0] hit_nonce = '0;
    logic         out_ready = 1'b0;

    logic [1:0]        ov, dn;
    logic [1:0][31:0]  on;
    logic [1:0][1:0]   oc;
    logic [1:0][15:0]  rc, dc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    golden_nonce_collector #(.CHANNELS(4), .NONCE_W(32), .FIFO_DEPTH(8), .MAX_RESULTS(0)) dut0 (
        .clk(clk), .reset(rst), .enable(enable), .hit(hit), .hit_nonce(hit_nonce),
        .out_valid(ov[0]), .out_ready(out_ready), .out_nonce(on[0]), .out_channel(oc[0]),
        .result_count(rc[0]), .drop_count(dc[0]), .done(dn[0]));

    golden_nonce_collector #(.CHANNELS(4), .NONCE_W(32), .FIFO_DEPTH(8), .MAX_RESULTS(1)) dut1 (
        .clk(clk), .reset(rst), .enable(enable), .hit(hit), .hit_nonce(hit_nonce),
        .out_valid(ov[1]), .out_ready(out_ready), .out_nonce(on[1]), .out_channel(oc[1]),
        .result_count(rc[1]), .drop_count(dc[1]), .done(dn[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: 0 idle, 1 run, 2 done; FIFO kept as a circular array with head/count.
    int          m_st [2];
    bit          m_sv [2][4];
    logic [31:0] m_sn [2][4];
    int          m_ptr[2];
    logic [31:0] m_fn [2][8];
    int          m_fc [2][8];
    int          m_head[2], m_cnt[2], m_rc[2], m_dc[2];

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_ptr[k] = 0; m_head[k] = 0; m_cnt[k] = 0; m_rc[k] = 0; m_dc[k] = 0;
            for (int i = 0; i < 4; i++) begin m_sv[k][i] = 0; m_sn[k][i] = '0; end
        end
    endtask

    task automatic m_step(input int k, input int maxr);
        bit run, pop, can, drop;
        int g, ns;
        run = (m_st[k] == 1);
        pop = (m_cnt[k] > 0) && out_ready;
        can = (m_cnt[k] < 8) || pop;
        g = -1;
        if (run && can)
            for (int j = 0; j < 4; j++) begin
                int c = (m_ptr[k] + j) % 4;
                if (g < 0 && m_sv[k][c]) g = c;
            end
        drop = 0;
        if (run)
            for (int i = 0; i < 4; i++)
                if (hit[i] && m_sv[k][i] && i != g) drop = 1;
        ns = m_st[k];
        case (m_st[k])
            0: if (enable) ns = 1;
            1: if (!enable) ns = 0;
               else if (pop && maxr != 0 && m_rc[k] + 1 == maxr) ns = 2;
            default: if (!enable) ns = 0;
        endcase
        if (m_st[k] == 0 && enable) begin
            m_rc[k] = 0; m_dc[k] = 0;
        end else if (run) begin
            if (pop && m_rc[k] < 65535) m_rc[k]++;
            if (drop && m_dc[k] < 65535) m_dc[k]++;
        end
        if (pop) begin m_head[k] = (m_head[k] + 1) % 8; m_cnt[k]--; end
        if (g >= 0) begin
            m_fn[k][(m_head[k] + m_cnt[k]) % 8] = m_sn[k][g];
            m_fc[k][(m_head[k] + m_cnt[k]) % 8] = g;
            m_cnt[k]++;
            m_ptr[k] = (g + 1) % 4;
        end
        if (run && ns != 1) begin
            for (int i = 0; i < 4; i++) m_sv[k][i] = 0;
        end else if (run) begin
            for (int i = 0; i < 4; i++)
                if (hit[i] && (!m_sv[k][i] || i == g)) begin
                    m_sv[k][i] = 1; m_sn[k][i] = hit_nonce[i*32 +: 32];
                end else if (i == g) m_sv[k][i] = 0;
        end
        m_st[k] = ns;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else begin m_step(0, 0); m_step(1, 1); end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("m%0d_out_valid", k), 32'(ov[k]), 32'(m_cnt[k] > 0));
                if (m_cnt[k] > 0) begin
                    chk($sformatf("m%0d_out_nonce", k), on[k], m_fn[k][m_head[k]]);
                    chk($sformatf("m%0d_out_channel", k), 32'(oc[k]), 32'(m_fc[k][m_head[k]]));
                end
                chk($sformatf("m%0d_result_count", k), 32'(rc[k]), 32'(m_rc[k]));
                chk($sformatf("m%0d_drop_count", k), 32'(dc[k]), 32'(m_dc[k]));
                chk($sformatf("m%0d_done", k), 32'(dn[k]), 32'(m_st[k] == 2));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hit(input int ch, input logic [31:0] v);
        hit[ch] = 1'b1;
        hit_nonce[ch*32 +: 32] = v;
    endtask

    initial begin
        int n, pops;
        logic [31:0] last1;
        logic [15:0] rcsave;

        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            chk("reset_out_valid", 32'(ov[k]), 0);
            chk("reset_out_nonce", on[k], 0);
            chk("reset_out_channel", 32'(oc[k]), 0);
            chk("reset_result_count", 32'(rc[k]), 0);
            chk("reset_drop_count", 32'(dc[k]), 0);
            chk("reset_done", 32'(dn[k]), 0);
        end
        rst = 1'b0;

        // T1: single hit on channel 2
        enable = 1'b1;
        tick();
        out_ready = 1'b1;
        set_hit(2, 32'h0000_1234);
        tick();
        hit = '0;
        tick();
        chk("t1_out_valid", 32'(ov[1]), 1);
        chk("t1_out_channel", 32'(oc[1]), 2);
        chk("t1_out_nonce", on[1], 32'h1234);
        tick();
        chk("t1_done", 32'(dn[1]), 1);
        chk("t1_result_count", 32'(rc[1]), 1);
        chk("t1_done_unlimited", 32'(dn[0]), 0);

        // T2: all four channels at once, fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_hit(i, 32'(i + 1));
        tick();
        hit = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_out_channel", 32'(oc[0]), 32'(i));
            chk("t2_out_nonce", on[0], 32'(i + 1));
        end
        tick();
        chk("t2_result_count", 32'(rc[0]), 4);

        // T3: 12 hits with consumer stalled
        out_ready = 1'b0;
        for (int j = 0; j < 12; j++) begin
            hit = '0;
            set_hit(j % 4, 32'h300 + 32'(j));
            tick();
        end
        hit = '0;
        tick(); tick();
        chk("t3_stalled_valid", 32'(ov[0]), 1);
        out_ready = 1'b1;
        n = 0;
        while (ov[0] && n < 40) begin tick(); n++; end
        chk("t3_drain_in_time", 32'(n < 40), 1);
        chk("t3_result_count", 32'(rc[0]), 16);
        chk("t3_drop_count", 32'(dc[0]), 0);

        // T4: two hits on channel 1 while FIFO full
        out_ready = 1'b0;
        for (int j = 0; j < 8; j++) begin
            hit = '0;
            set_hit(j % 4, 32'h400 + 32'(j));
            tick();
        end
        hit = '0;
        tick();
        set_hit(1, 32'hAAAA);
        tick();
        hit = '0;
        set_hit(1, 32'hBBBB);
        tick();
        hit = '0;
        tick();
        chk("t4_drop_count", 32'(dc[0]), 1);
        out_ready = 1'b1;
        last1 = '0;
        n = 0;
        while (ov[0] && n < 40) begin
            if (oc[0] == 2'd1) last1 = on[0];
            tick();
            n++;
        end
        chk("t4_drain_in_time", 32'(n < 40), 1);
        chk("t4_kept_nonce", last1, 32'hAAAA);
        chk("t4_result_count", 32'(rc[0]), 25);

        // T5: asynchronous reset with 3 entries queued
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) set_hit(i, 32'h500 + 32'(i));
        tick();
        hit = '0;
        tick(); tick(); tick();
        chk("t5_pre_valid", 32'(ov[0]), 1);
        chk("t5_pre_done", 32'(dn[1]), 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_out_valid", 32'(ov[0]), 0);
        chk("t5_result_count", 32'(rc[0]), 0);
        chk("t5_done", 32'(dn[1]), 0);
        tick();
        rst = 1'b0;

        // T6: leave RUN with 2 entries queued
        enable = 1'b1;
        tick();
        set_hit(0, 32'h600);
        set_hit(3, 32'h603);
        tick();
        hit = '0;
        tick(); tick();
        rcsave = rc[0];
        enable = 1'b0;
        tick();
        for (int j = 0; j < 3; j++) begin
            hit = 4'($urandom);
            hit_nonce = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        hit = '0;
        out_ready = 1'b1;
        pops = 0;
        n = 0;
        while (ov[0] && n < 20) begin pops++; tick(); n++; end
        chk("t6_pops", 32'(pops), 2);
        chk("t6_result_count", 32'(rc[0]), 32'(rcsave));

        // Randomized traffic
        rst = 1'b1;
        tick();
        rst = 1'b0;
        enable = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            int rdy_pct;
            rdy_pct = ((c / 200) % 3 == 0) ? 20 : ((c / 200) % 3 == 1) ? 60 : 95;
            if ($urandom_range(0, 99) < 2) enable = ~enable;
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            hit = 4'($urandom & $urandom);
            hit_nonce = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        hit = '0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
